// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
// Runs a W-bit (W = 4*NIBBLES) operation through an external 4-bit ALU, one
// nibble per clock, LSB nibble first, rippling the ALU carry between passes.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               operation request, sampled only when not busy
//   in_a, in_b          W-bit operands
//   in_cin              carry into nibble 0
//   in_op, in_l         ALU operation code / logic-arith select (passed through)
//   alu_a, alu_b        current operand nibbles to the ALU
//   alu_cin             carry in to the ALU
//   alu_op, alu_l       latched operation controls to the ALU
//   alu_r               ALU nibble result (combinational from alu_*)
//   alu_z, alu_c, alu_s ALU nibble flags
//   busy                high while nibbles are being processed
//   done                one-cycle pulse when result and flags are valid
//   result              assembled W-bit result
//   z, c, s             whole-word zero, carry and sign flags
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  input  logic [1:0]             in_op,
  input  logic                   in_l,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [1:0]             alu_op,
  output logic                   alu_l,
  input  logic [3:0]             alu_r,
  input  logic                   alu_z,
  input  logic                   alu_c,
  input  logic                   alu_s,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   z,
  output logic                   c,
  output logic                   s
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            cin_r;
  logic [1:0]      op_r;
  logic            l_r;
  logic            carry_r;
  logic            zacc_r;
  logic [W-1:0]    result_r;
  logic            z_r;
  logic            c_r;
  logic            s_r;
  logic            busy_r;
  logic            done_r;

  logic [3:0]      nib_a_s;
  logic [3:0]      nib_b_s;
  logic [W-1:0]    result_next_s;
  logic            zacc_next_s;
  logic            first_s;
  logic            last_s;

  assign first_s = (cnt_r == {CW{1'b0}});
  assign last_s  = (cnt_r == CW'(NIBBLES - 1));

  // Select the current operand nibbles and splice alu_r into the result word.
  always_comb begin
    nib_a_s       = 4'h0;
    nib_b_s       = 4'h0;
    result_next_s = result_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_r == CW'(i)) begin
        nib_a_s                  = a_r[4*i +: 4];
        nib_b_s                  = b_r[4*i +: 4];
        result_next_s[4*i +: 4]  = alu_r;
      end else begin
        result_next_s[4*i +: 4]  = result_r[4*i +: 4];
      end
    end
  end

  // Zero flag accumulates across nibbles; nibble 0 restarts it.
  always_comb begin
    if (first_s) begin
      zacc_next_s = alu_z;
    end else begin
      zacc_next_s = zacc_r & alu_z;
    end
  end

  // ALU operand drive: only live in RUN so a reset or idle sequencer shows zeros.
  always_comb begin
    if (state_r == RUN) begin
      alu_a   = nib_a_s;
      alu_b   = nib_b_s;
      alu_cin = first_s ? cin_r : carry_r;
    end else begin
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_cin = 1'b0;
    end
  end

  assign alu_op = op_r;
  assign alu_l  = l_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign z      = z_r;
  assign c      = c_r;
  assign s      = s_r;

  // Sequencer state, operand latch, nibble capture and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      cin_r    <= 1'b0;
      op_r     <= 2'b00;
      l_r      <= 1'b0;
      carry_r  <= 1'b0;
      zacc_r   <= 1'b0;
      result_r <= {W{1'b0}};
      z_r      <= 1'b0;
      c_r      <= 1'b0;
      s_r      <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= in_a;
            b_r     <= in_b;
            cin_r   <= in_cin;
            op_r    <= in_op;
            l_r     <= in_l;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here so latched operands stay stable.
          result_r <= result_next_s;
          carry_r  <= alu_c;
          zacc_r   <= zacc_next_s;
          if (last_s) begin
            z_r     <= zacc_next_s;
            c_r     <= alu_c;
            s_r     <= alu_s;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          cnt_r   <= {CW{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq with a behavioural 4-bit ALU attached.
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         s;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [1:0]    in_op;
  logic          in_l;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic          alu_cin;
  logic [1:0]    alu_op;
  logic          alu_l;
  logic [3:0]    alu_r;
  logic          alu_z;
  logic          alu_c;
  logic          alu_s;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          z;
  logic          c;
  logic          s;

  int   checks;
  int   errors;
  exp_t sb[$];

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op), .in_l(in_l),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_l(alu_l),
    .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_s(alu_s),
    .busy(busy), .done(done), .result(result), .z(z), .c(c), .s(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: l=0 arithmetic (00 add, 01 sub a+~b+cin), l=1 logic.
  always_comb begin
    logic [4:0] full;
    full = 5'd0;
    if (!alu_l) begin
      if (alu_op == 2'b01) full = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      else                 full = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    end else begin
      case (alu_op)
        2'b00:   full = {1'b0, alu_a & alu_b};
        2'b01:   full = {1'b0, alu_a | alu_b};
        2'b10:   full = {1'b0, alu_a ^ alu_b};
        default: full = {1'b0, ~alu_a};
      endcase
    end
    alu_r = full[3:0];
    alu_c = full[4];
    alu_z = (full[3:0] == 4'h0);
    alu_s = full[3];
  end

  // W-bit reference for the same operation set.
  function automatic exp_t ref_op(logic [W-1:0] a, logic [W-1:0] b, logic cin,
                                  logic [1:0] op, logic l);
    logic [W:0] full;
    exp_t       e;
    if (!l) begin
      if (op == 2'b01) full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
      else             full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end else begin
      case (op)
        2'b00:   full = {1'b0, a & b};
        2'b01:   full = {1'b0, a | b};
        2'b10:   full = {1'b0, a ^ b};
        default: full = {1'b0, ~a};
      endcase
    end
    e.r = full[W-1:0];
    e.c = full[W];
    e.z = (full[W-1:0] == {W{1'b0}});
    e.s = full[W-1];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge and record its expected outcome.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [1:0] op, input logic l);
    in_a   = a;
    in_b   = b;
    in_cin = cin;
    in_op  = op;
    in_l   = l;
    start  = 1'b1;
    sb.push_back(ref_op(a, b, cin, op, l));
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(e.r));
      chk({tag, "_z"}, 32'(z), 32'(e.z));
      chk({tag, "_c"}, 32'(c), 32'(e.c));
      chk({tag, "_s"}, 32'(s), 32'(e.s));
    end
  endtask

  // Wait (bounded) for done, check latency from the launch negedge, then score.
  task automatic finish_op(input string tag, input bit keep_start);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_start) start = 1'b0;
      lat++;
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(NIBBLES + 1));
    if (got) pop_compare(tag);
    else if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    logic [W-1:0] orig_a;
    logic [W-1:0] orig_b;
    logic [W-1:0] tmp;
    logic [3:0]   cin_seq;
    int           dones;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_cin = 1'b0;
    in_op  = 2'b00;
    in_l   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({z, c, s}), 32'd0);
    chk("rst_alu_ab", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    chk("rst_alu_ctl", 32'({alu_op, alu_l}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Add with carry ripple: per-nibble carry-in sequence 0,1,1,0
    cin_seq = 4'b0110;
    launch(16'h00FF, 16'h0001, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      chk($sformatf("ripple_busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("ripple_cin%0d", k), 32'(alu_cin), 32'(cin_seq[k]));
    end
    @(negedge clk);
    chk("ripple_done", 32'(done), 32'd1);
    chk("ripple_busy_off", 32'(busy), 32'd0);
    pop_compare("ripple");
    @(negedge clk);
    chk("ripple_done_pulse", 32'(done), 32'd0);

    // Full wrap and sign/carry-in cases
    launch(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0);
    finish_op("wrap", 1'b0);
    launch(16'h7FFF, 16'h0000, 1'b1, 2'b00, 1'b0);
    finish_op("sign", 1'b0);
    @(negedge clk);

    // Reset mid-operation at cnt=2
    in_a   = 16'h1234;
    in_b   = 16'h5678;
    in_cin = 1'b0;
    in_op  = 2'b00;
    in_l   = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_alu_a", 32'(alu_a), 32'h2);
    reset = 1'b1;
    #1;
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Busy protection: new operands offered in every RUN cycle are ignored
    orig_a = 16'hA5C3;
    orig_b = 16'h1E2D;
    launch(orig_a, orig_b, 1'b1, 2'b00, 1'b0);
    dones = 0;
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      tmp = orig_a >> (4 * k);
      chk($sformatf("prot_alu_a%0d", k), 32'(alu_a), 32'(tmp[3:0]));
      tmp = orig_b >> (4 * k);
      chk($sformatf("prot_alu_b%0d", k), 32'(alu_b), 32'(tmp[3:0]));
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      in_op = 2'b01;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    if (done === 1'b1) dones++;
    pop_compare("prot");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("prot_one_done", 32'(dones), 32'd1);

    // Back-to-back: start held high, next op launched in each DONE cycle
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      finish_op($sformatf("b2b%0d", i), (i != 5));
    end
    chk("b2b_ctl_hold", 32'({alu_op, alu_l}), 32'({in_op, in_l}));
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
